// File: rtl/bridge_bus_pkg.sv
// Shared widths, FSM state encoding and index-width helper for the bridge bus arbiter.
package bridge_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bridge_rr_pick.sv
// Round-robin picker: first pending requester at or after the pointer, with wrap.
module bridge_rr_pick
  import bridge_bus_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] i_pend,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_grant,
  output logic             o_any
);

  int w_idx;

  // Scan from farthest to nearest so the nearest pending slot is written last and wins.
  always_comb begin
    o_grant = '0;
    o_any   = |i_pend;
    w_idx   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_idx = (int'(i_ptr) + i) % N_REQ;
      if (i_pend[w_idx]) begin
        o_grant = w_idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bridge_bus_arbiter.sv
// Shares the core register bus between N_REQ host bridges, one transaction at a time.
//
// state | meaning
// IDLE  | no transaction outstanding; issue the round-robin winner if any is pending
// WAIT  | transaction on the bus; wait for bus_valid_i or the timeout count
module bridge_bus_arbiter
  import bridge_bus_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W*N_REQ-1:0] req_addr_i,
  input  logic [DATA_W*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_rw_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [ADDR_W-1:0]       bus_addr_o,
  output logic [DATA_W-1:0]       bus_data_o,
  output logic                    bus_rw_o,
  output logic                    bus_valid_o,
  input  logic [DATA_W-1:0]       bus_data_i,
  input  logic                    bus_valid_i,
  output logic [DATA_W-1:0]       resp_data_o,
  output logic                    resp_rw_o,
  output logic [N_REQ-1:0]        resp_valid_o,
  output logic                    resp_timeout_o,
  output logic [N_REQ-1:0]        overflow_o
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = 16;
  // The counter starts at 0 in the issue cycle, so the last WAIT cycle holds TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic               w_issue;
  logic               w_resp_real;
  logic               w_resp_tmo;

  logic [N_REQ-1:0]   r_pend;
  logic [N_REQ-1:0]   r_overflow;
  logic [ADDR_W-1:0]  r_hold_addr [N_REQ];
  logic [DATA_W-1:0]  r_hold_data [N_REQ];
  logic [N_REQ-1:0]   r_hold_rw;

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic               r_cur_rw;
  logic [CNT_W-1:0]   r_cnt;

  logic [ADDR_W-1:0]  r_bus_addr;
  logic [DATA_W-1:0]  r_bus_data;
  logic               r_bus_rw;
  logic               r_bus_valid;
  logic [DATA_W-1:0]  r_resp_data;
  logic               r_resp_rw;
  logic [N_REQ-1:0]   r_resp_valid;
  logic               r_resp_timeout;

  logic [IDX_W-1:0]   w_grant;
  logic               w_any;
  logic [IDX_W-1:0]   w_ptr_next;
  logic [N_REQ-1:0]   w_clear;

  bridge_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_pend  (r_pend),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  // Pointer moves to the slot after the winner, wrapping at N_REQ.
  always_comb begin
    w_ptr_next = '0;
    if (w_grant != IDX_W'(N_REQ - 1)) begin
      w_ptr_next = w_grant + 1'b1;
    end
  end

  // Pending bit of the issued requester is released in the issue cycle.
  always_comb begin
    w_clear = '0;
    if (w_issue) begin
      w_clear = N_REQ'(1) << w_grant;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and one-cycle control strobes; a real response beats the timeout.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_resp_real  = 1'b0;
    w_resp_tmo   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_issue      = 1'b1;
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        if (bus_valid_i) begin
          w_resp_real  = 1'b1;
          w_next_state = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_resp_tmo   = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Per-requester capture: a pulse onto a still-pending slot is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_overflow <= '0;
      r_hold_rw  <= '0;
      for (int k = 0; k < N_REQ; k++) begin
        r_hold_addr[k] <= '0;
        r_hold_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (req_valid_i[k]) begin
          if (r_pend[k] && !w_clear[k]) begin
            r_overflow[k] <= 1'b1;
          end else begin
            r_hold_addr[k] <= req_addr_i[ADDR_W*k +: ADDR_W];
            r_hold_data[k] <= req_data_i[DATA_W*k +: DATA_W];
            r_hold_rw[k]   <= req_rw_i[k];
            r_pend[k]      <= 1'b1;
          end
        end else if (w_clear[k]) begin
          r_pend[k] <= 1'b0;
        end
      end
    end
  end

  // Issue bookkeeping and the WAIT cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_cur_rw <= 1'b0;
      r_cnt    <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= w_ptr_next;
      r_owner  <= w_grant;
      r_cur_rw <= r_hold_rw[w_grant];
      r_cnt    <= '0;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered bus and response outputs, forced to zero when their strobe is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_addr     <= '0;
      r_bus_data     <= '0;
      r_bus_rw       <= 1'b0;
      r_bus_valid    <= 1'b0;
      r_resp_data    <= '0;
      r_resp_rw      <= 1'b0;
      r_resp_valid   <= '0;
      r_resp_timeout <= 1'b0;
    end else begin
      r_bus_valid    <= w_issue;
      r_bus_addr     <= w_issue ? r_hold_addr[w_grant] : '0;
      r_bus_data     <= w_issue ? r_hold_data[w_grant] : '0;
      r_bus_rw       <= w_issue ? r_hold_rw[w_grant] : 1'b0;
      r_resp_valid   <= (w_resp_real || w_resp_tmo) ? (N_REQ'(1) << r_owner) : '0;
      r_resp_data    <= w_resp_real ? bus_data_i : '0;
      r_resp_rw      <= (w_resp_real || w_resp_tmo) ? r_cur_rw : 1'b0;
      r_resp_timeout <= w_resp_tmo;
    end
  end

  assign bus_addr_o     = r_bus_addr;
  assign bus_data_o     = r_bus_data;
  assign bus_rw_o       = r_bus_rw;
  assign bus_valid_o    = r_bus_valid;
  assign resp_data_o    = r_resp_data;
  assign resp_rw_o      = r_resp_rw;
  assign resp_valid_o   = r_resp_valid;
  assign resp_timeout_o = r_resp_timeout;
  assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_bridge_bus_arbiter.sv
// Bench for bridge_bus_arbiter with two requesters and an 8-cycle timeout.
module tb_bridge_bus_arbiter;

  localparam int N = 2;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   req_addr_i = '0;
  logic [31:0]   req_data_i = '0;
  logic [1:0]    req_rw_i = '0;
  logic [1:0]    req_valid_i = '0;
  logic [15:0]   bus_addr_o;
  logic [15:0]   bus_data_o;
  logic          bus_rw_o;
  logic          bus_valid_o;
  logic [15:0]   bus_data_i = '0;
  logic          bus_valid_i = 1'b0;
  logic [15:0]   resp_data_o;
  logic          resp_rw_o;
  logic [1:0]    resp_valid_o;
  logic          resp_timeout_o;
  logic [1:0]    overflow_o;

  int n_cmp = 0;
  int n_err = 0;

  bridge_bus_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_addr_i     (req_addr_i),
    .req_data_i     (req_data_i),
    .req_rw_i       (req_rw_i),
    .req_valid_i    (req_valid_i),
    .bus_addr_o     (bus_addr_o),
    .bus_data_o     (bus_data_o),
    .bus_rw_o       (bus_rw_o),
    .bus_valid_o    (bus_valid_o),
    .bus_data_i     (bus_data_i),
    .bus_valid_i    (bus_valid_i),
    .resp_data_o    (resp_data_o),
    .resp_rw_o      (resp_rw_o),
    .resp_valid_o   (resp_valid_o),
    .resp_timeout_o (resp_timeout_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rw;
    int          delay;     // cycles after issue that bus_valid_i arrives; -1 = never
    logic [15:0] rdata;
    logic [1:0]  exp_onehot;
    logic [15:0] exp_rdata;
    logic        exp_to;
  } vec_t;

  vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] d, input logic rw);
    req_addr_i[16*k +: 16] = a;
    req_data_i[16*k +: 16] = d;
    req_rw_i[k]            = rw;
    req_valid_i[k]         = 1'b1;
  endtask

  task automatic clr_req();
    req_addr_i  = '0;
    req_data_i  = '0;
    req_rw_i    = '0;
    req_valid_i = '0;
  endtask

  task automatic bus_resp(input logic [15:0] d);
    bus_valid_i = 1'b1;
    bus_data_i  = d;
  endtask

  task automatic bus_idle();
    bus_valid_i = 1'b0;
    bus_data_i  = '0;
  endtask

  task automatic wait_issue(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_valid_o) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: bus_valid_o still 0 after 20 cycles, expected 1", name);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int exp_c;
    exp_c = (v.delay >= 0) ? v.delay : TMO - 1;
    set_req(v.k, v.addr, v.wdata, v.rw);
    step();
    clr_req();
    chk($sformatf("v%0d_early", idx), bus_valid_o, 0);
    step();
    chk($sformatf("v%0d_bus_valid", idx), bus_valid_o, 1);
    chk($sformatf("v%0d_bus_addr", idx), bus_addr_o, v.addr);
    chk($sformatf("v%0d_bus_data", idx), bus_data_o, v.wdata);
    chk($sformatf("v%0d_bus_rw", idx), bus_rw_o, v.rw);
    for (int c = 0; c <= exp_c; c++) begin
      if (c == v.delay) bus_resp(v.rdata);
      step();
      bus_idle();
      if (c == 0 && exp_c > 0) begin
        chk($sformatf("v%0d_bus_single", idx), bus_valid_o, 0);
        chk($sformatf("v%0d_bus_addr_zero", idx), bus_addr_o, 0);
      end
      if (c < exp_c) chk($sformatf("v%0d_resp_early_c%0d", idx, c), resp_valid_o, 0);
    end
    chk($sformatf("v%0d_resp_valid", idx), resp_valid_o, v.exp_onehot);
    chk($sformatf("v%0d_resp_data", idx), resp_data_o, v.exp_rdata);
    chk($sformatf("v%0d_resp_rw", idx), resp_rw_o, v.rw);
    chk($sformatf("v%0d_resp_to", idx), resp_timeout_o, v.exp_to);
    step();
    chk($sformatf("v%0d_resp_drop", idx), resp_valid_o, 0);
    chk($sformatf("v%0d_resp_data_zero", idx), resp_data_o, 0);
  endtask

  initial begin
    logic [15:0] ea;
    int e;
    bit seen;

    vecs[0] = '{k:0, addr:16'h1234, wdata:16'h0000, rw:1'b0, delay:3,  rdata:16'hBEEF,
                exp_onehot:2'b01, exp_rdata:16'hBEEF, exp_to:1'b0};
    vecs[1] = '{k:1, addr:16'h00F0, wdata:16'h5A5A, rw:1'b1, delay:0,  rdata:16'h5A5A,
                exp_onehot:2'b10, exp_rdata:16'h5A5A, exp_to:1'b0};
    vecs[2] = '{k:1, addr:16'hFFFF, wdata:16'h7777, rw:1'b0, delay:7,  rdata:16'h0001,
                exp_onehot:2'b10, exp_rdata:16'h0001, exp_to:1'b0};
    vecs[3] = '{k:0, addr:16'h8000, wdata:16'h0000, rw:1'b0, delay:-1, rdata:16'h0000,
                exp_onehot:2'b01, exp_rdata:16'h0000, exp_to:1'b1};
    vecs[4] = '{k:0, addr:16'h4321, wdata:16'h0F0F, rw:1'b1, delay:1,  rdata:16'h0F0F,
                exp_onehot:2'b01, exp_rdata:16'h0F0F, exp_to:1'b0};

    // Reset state
    repeat (3) step();
    chk("rst_bus_valid", bus_valid_o, 0);
    chk("rst_bus_addr", bus_addr_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_overflow", overflow_o, 0);
    rst_n = 1'b1;
    step();

    // Simultaneous requests, pointer at 0
    set_req(0, 16'h0010, 16'hAAAA, 1'b1);
    set_req(1, 16'h0020, 16'h0000, 1'b0);
    step();
    clr_req();
    chk("sim_early", bus_valid_o, 0);
    step();
    chk("sim_first_valid", bus_valid_o, 1);
    chk("sim_first_addr", bus_addr_o, 16'h0010);
    chk("sim_first_data", bus_data_o, 16'hAAAA);
    chk("sim_first_rw", bus_rw_o, 1);
    bus_resp(16'hAAAA);
    step();
    bus_idle();
    chk("sim_resp0_valid", resp_valid_o, 2'b01);
    chk("sim_resp0_rw", resp_rw_o, 1);
    chk("sim_resp0_data", resp_data_o, 16'hAAAA);
    chk("sim_no_b2b", bus_valid_o, 0);
    step();
    chk("sim_second_valid", bus_valid_o, 1);
    chk("sim_second_addr", bus_addr_o, 16'h0020);
    chk("sim_second_rw", bus_rw_o, 0);
    bus_resp(16'h1357);
    step();
    bus_idle();
    chk("sim_resp1_valid", resp_valid_o, 2'b10);
    chk("sim_resp1_data", resp_data_o, 16'h1357);
    chk("sim_resp1_rw", resp_rw_o, 0);
    step();

    // Fairness: both refill after each response; grants alternate
    set_req(0, 16'hA000, 16'h0000, 1'b0);
    set_req(1, 16'hA100, 16'h0000, 1'b0);
    step();
    clr_req();
    for (int r = 0; r < 6; r++) begin
      e  = r % 2;
      ea = 16'hA000 | 16'(e << 8) | 16'(r / 2);
      wait_issue($sformatf("fair_r%0d_issue", r));
      chk($sformatf("fair_r%0d_addr", r), bus_addr_o, ea);
      bus_resp(ea);
      step();
      bus_idle();
      chk($sformatf("fair_r%0d_resp", r), resp_valid_o, (e == 1) ? 2'b10 : 2'b01);
      if (r < 4) begin
        set_req(e, 16'hA000 | 16'(e << 8) | 16'(r / 2 + 1), 16'h0000, 1'b0);
        step();
        clr_req();
      end
    end
    repeat (3) step();

    // Single-transaction vector table
    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Overflow: second pulse from req1 while its first is still pending
    set_req(0, 16'h0100, 16'h0000, 1'b0);
    step();
    clr_req();
    step();
    chk("ovf_issue0_addr", bus_addr_o, 16'h0100);
    set_req(1, 16'h0201, 16'h0000, 1'b0);
    step();
    clr_req();
    chk("ovf_none_yet", overflow_o, 2'b00);
    set_req(1, 16'h0202, 16'h0000, 1'b0);
    step();
    clr_req();
    chk("ovf_flag", overflow_o, 2'b10);
    bus_resp(16'h1111);
    step();
    bus_idle();
    chk("ovf_resp0", resp_valid_o, 2'b01);
    step();
    chk("ovf_issue1_valid", bus_valid_o, 1);
    chk("ovf_issue1_addr", bus_addr_o, 16'h0201);
    bus_resp(16'h2222);
    step();
    bus_idle();
    chk("ovf_resp1", resp_valid_o, 2'b10);
    chk("ovf_resp1_data", resp_data_o, 16'h2222);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus_valid_o) seen = 1'b1;
    end
    chk("ovf_dropped_never_issued", seen, 0);
    chk("ovf_sticky", overflow_o, 2'b10);

    // Timeout on req1 followed by a late bus response in IDLE
    set_req(1, 16'h0C0C, 16'h0000, 1'b0);
    step();
    clr_req();
    step();
    chk("tmo_issue", bus_valid_o, 1);
    repeat (TMO - 1) step();
    chk("tmo_not_early", resp_valid_o, 0);
    step();
    chk("tmo_resp_valid", resp_valid_o, 2'b10);
    chk("tmo_flag", resp_timeout_o, 1);
    chk("tmo_data", resp_data_o, 0);
    bus_resp(16'hDEAD);
    step();
    bus_idle();
    chk("tmo_late_ignored", resp_valid_o, 0);
    chk("tmo_late_flag", resp_timeout_o, 0);
    step();
    chk("tmo_late_ignored2", resp_valid_o, 0);
    chk("tmo_late_no_issue", bus_valid_o, 0);

    // Reset in the middle of WAIT
    set_req(0, 16'h0555, 16'h0000, 1'b0);
    step();
    clr_req();
    step();
    chk("rw_issue", bus_valid_o, 1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("rw_ovf_clear", overflow_o, 0);
    chk("rw_resp_zero", resp_valid_o, 0);
    chk("rw_bus_zero", bus_valid_o, 0);
    step();
    step();
    rst_n = 1'b1;
    bus_resp(16'h3333);
    step();
    bus_idle();
    chk("rw_no_resp", resp_valid_o, 0);
    step();
    chk("rw_no_resp2", resp_valid_o, 0);
    chk("rw_no_issue", bus_valid_o, 0);
    set_req(1, 16'h0777, 16'h0999, 1'b1);
    step();
    clr_req();
    step();
    chk("rw_new_valid", bus_valid_o, 1);
    chk("rw_new_addr", bus_addr_o, 16'h0777);
    chk("rw_new_data", bus_data_o, 16'h0999);
    chk("rw_new_rw", bus_rw_o, 1);
    bus_resp(16'h0999);
    step();
    bus_idle();
    chk("rw_new_resp", resp_valid_o, 2'b10);
    chk("rw_new_resp_data", resp_data_o, 16'h0999);
    chk("rw_new_resp_rw", resp_rw_o, 1);
    chk("rw_new_resp_to", resp_timeout_o, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
